// File: rtl/count_seq_pkg.sv
// Shared types and defaults for the count sequencer and its prescaler.
package count_seq_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_PWIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // True for the states in which a period is in progress (busy).
    function automatic logic is_active(input state_t s);
        return (s == ST_RUN) || (s == ST_HOLD);
    endfunction

endpackage

// File: rtl/count_prescaler.sv
// Clock-cycle divider: emits a one-cycle step strobe every (div+1) enabled
// cycles. The phase counter is frozen while enable is low, so pausing never
// loses or gains partial progress toward the next step.
module count_prescaler #(
    parameter int PWIDTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [PWIDTH-1:0] div,
    output logic              step
);

    logic [PWIDTH-1:0] phase;

    // The step is combinational from the phase so the owner can act on the
    // same edge the phase wraps; clear always wins over a pending step.
    assign step = enable && !clear && (phase == div);

    // Phase counter: reset/clear to 0, wrap to 0 when it reaches div.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (enable) begin
            if (phase == div) begin
                phase <= '0;
            end else begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule

// File: rtl/count_sequencer.sv
// Period sequencer: counts prescaled steps from 0 to period-1, pulses tick on
// each terminal count, and either reloads (periodic) or parks in DONE
// (one-shot). Supports hold (pause) and abort. All outputs are registered.
//
// Control protocol: start is a level sampled only while IDLE or DONE; the
// launch happens on the edge that samples it and is not acknowledged other
// than by busy rising. abort is sampled on every edge and overrides all other
// inputs. state_dbg mirrors the FSM state register for observation.
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PWIDTH = DEF_PWIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic              auto_reload,
    input  logic [WIDTH-1:0]  period,
    input  logic [PWIDTH-1:0] prescale,
    output logic [WIDTH-1:0]  count,
    output logic              busy,
    output logic              tick,
    output logic              done,
    output logic              err,
    output logic [1:0]        state_dbg
);

    state_t            state;
    state_t            next_state;
    logic [WIDTH-1:0]  period_l;
    logic [PWIDTH-1:0] prescale_l;
    logic              auto_reload_l;

    logic              launch;
    logic              wrap;
    logic              err_next;
    logic              pre_clear;
    logic              pre_enable;
    logic              step;
    logic [WIDTH-1:0]  last_count;

    assign state_dbg  = state;

    // Terminal value; period_l is never 0 while running, so no underflow.
    assign last_count = period_l - 1'b1;

    // Counters advance only while a period is in progress and hold is low;
    // a hold on the same edge as a step therefore suppresses that step.
    assign pre_enable = is_active(state) && !hold && !abort;
    assign pre_clear  = abort || launch;

    count_prescaler #(
        .PWIDTH (PWIDTH)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .clear  (pre_clear),
        .enable (pre_enable),
        .div    (prescale_l),
        .step   (step)
    );

    // Next-state and per-edge event decode.
    always_comb begin
        next_state = state;
        launch     = 1'b0;
        wrap       = 1'b0;
        err_next   = 1'b0;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (period == '0) begin
                            err_next   = 1'b1;
                            next_state = ST_IDLE;
                        end else begin
                            launch     = 1'b1;
                            next_state = ST_RUN;
                        end
                    end
                end
                ST_RUN, ST_HOLD: begin
                    if (hold) begin
                        next_state = ST_HOLD;
                    end else begin
                        next_state = ST_RUN;
                        if (step && (count == last_count)) begin
                            wrap       = 1'b1;
                            next_state = auto_reload_l ? ST_RUN : ST_DONE;
                        end
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Shadow copies of the launch parameters, captured only on a launch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            period_l      <= '0;
            prescale_l    <= '0;
            auto_reload_l <= 1'b0;
        end else if (launch) begin
            period_l      <= period;
            prescale_l    <= prescale;
            auto_reload_l <= auto_reload;
        end
    end

    // Count register: cleared on abort/launch, advanced on each step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (abort || launch) begin
            count <= '0;
        end else if (step) begin
            if (wrap) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    // Registered status outputs derived from the state being entered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            tick <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            busy <= is_active(next_state);
            tick <= wrap;
            done <= (next_state == ST_DONE);
            err  <= err_next;
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench for count_sequencer: directed scenarios followed by
// randomized stimulus, compared each cycle against an elapsed-time model.
module tb_count_sequencer;

    localparam int WIDTH  = 8;
    localparam int PWIDTH = 4;
    localparam int EW     = WIDTH + 6;

    logic              clock;
    logic              reset;
    logic              start;
    logic              abort;
    logic              hold;
    logic              auto_reload;
    logic [WIDTH-1:0]  period;
    logic [PWIDTH-1:0] prescale;
    logic [WIDTH-1:0]  count;
    logic              busy;
    logic              tick;
    logic              done;
    logic              err;
    logic [1:0]        state_dbg;

    int n_compared = 0;
    int n_mismatch = 0;

    // Expected output words: {state[1:0], err, done, tick, busy, count}.
    logic [EW-1:0] exp_q[$];

    // Reference model: a period is tracked as elapsed active cycles since
    // launch; count and tick follow from division by the step length.
    bit m_run;
    bit m_done;
    bit m_hold_st;
    int m_active;
    int m_p;
    int m_s;
    bit m_ar;

    count_sequencer #(
        .WIDTH  (WIDTH),
        .PWIDTH (PWIDTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .hold        (hold),
        .auto_reload (auto_reload),
        .period      (period),
        .prescale    (prescale),
        .count       (count),
        .busy        (busy),
        .tick        (tick),
        .done        (done),
        .err         (err),
        .state_dbg   (state_dbg)
    );

    // Clock and reset.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatch++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_run     = 1'b0;
        m_done    = 1'b0;
        m_hold_st = 1'b0;
        m_active  = 0;
        m_p       = 0;
        m_s       = 0;
        m_ar      = 1'b0;
    endtask

    // Advance the model by one edge using the inputs the DUT sampled.
    task automatic model_edge();
        bit       e_tick;
        bit       e_err;
        int       e_count;
        int       e_state;
        e_tick = 1'b0;
        e_err  = 1'b0;
        if (abort) begin
            m_run     = 1'b0;
            m_done    = 1'b0;
            m_hold_st = 1'b0;
            m_active  = 0;
        end else if (!m_run) begin
            if (start) begin
                m_done = 1'b0;
                if (period == 0) begin
                    e_err = 1'b1;
                end else begin
                    m_p       = int'(period);
                    m_s       = int'(prescale);
                    m_ar      = auto_reload;
                    m_active  = 0;
                    m_run     = 1'b1;
                    m_hold_st = 1'b0;
                end
            end
        end else if (hold) begin
            m_hold_st = 1'b1;
        end else begin
            m_hold_st = 1'b0;
            m_active++;
            if (m_active % (m_p * (m_s + 1)) == 0) begin
                e_tick = 1'b1;
                if (!m_ar) begin
                    m_run  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end
        e_count = m_run ? (m_active / (m_s + 1)) % m_p : 0;
        e_state = m_done ? 3 : (!m_run ? 0 : (m_hold_st ? 2 : 1));
        exp_q.push_back({e_state[1:0], e_err, m_done, e_tick, m_run, e_count[WIDTH-1:0]});
    endtask

    // Scoreboard: pop one expected word and compare every output field.
    task automatic compare_all();
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check("count", 32'(count),     32'(e[WIDTH-1:0]));
            check("busy",  32'(busy),      32'(e[WIDTH]));
            check("tick",  32'(tick),      32'(e[WIDTH+1]));
            check("done",  32'(done),      32'(e[WIDTH+2]));
            check("err",   32'(err),       32'(e[WIDTH+3]));
            check("state", 32'(state_dbg), 32'(e[WIDTH+5:WIDTH+4]));
        end
    endtask

    // One clock: DUT and model advance, outputs checked 1 ns later.
    task automatic cycle();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    // Driver tasks.
    task automatic drive(input bit s, input bit a, input bit h, input bit ar,
                         input int p, input int ps);
        start       = s;
        abort       = a;
        hold        = h;
        auto_reload = ar;
        period      = WIDTH'(p);
        prescale    = PWIDTH'(ps);
    endtask

    task automatic launch(input int p, input int ps, input bit ar);
        drive(1'b1, 1'b0, 1'b0, ar, p, ps);
        cycle();
        drive(1'b0, 1'b0, 1'b0, ar, p, ps);
    endtask

    task automatic do_abort();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        check("rst_count", 32'(count),     32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_tick",  32'(tick),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_err",   32'(err),       32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        exp_q.delete();
    endtask

    initial begin
        bit h_burst;
        reset = 1'b1;
        model_clear();
        apply_reset();

        // Asynchronous reset in the middle of a period (period 5, count 3).
        launch(5, 0, 1'b1);
        repeat (3) cycle();
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_busy",  32'(busy),  32'd0);
        check("async_rst_tick",  32'(tick),  32'd0);
        check("async_rst_done",  32'(done),  32'd0);
        apply_reset();

        // Periodic, period 4, no prescale: ticks 4, 8, 12 after start.
        launch(4, 0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check("p4_tick", 32'(tick), (k % 4 == 0) ? 32'd1 : 32'd0);
            check("p4_count", 32'(count), 32'(k % 4));
            check("p4_busy", 32'(busy), 32'd1);
        end
        do_abort();

        // One-shot, period 3, prescale 2: tick and done at cycle 9.
        launch(3, 2, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cycle();
            check("os_tick", 32'(tick), (k == 9) ? 32'd1 : 32'd0);
            check("os_done", 32'(done), (k >= 9) ? 32'd1 : 32'd0);
            check("os_count", 32'(count), (k >= 9) ? 32'd0 : 32'(k / 3));
        end
        launch(3, 2, 1'b0);
        check("relaunch_done", 32'(done), 32'd0);
        check("relaunch_busy", 32'(busy), 32'd1);
        do_abort();

        // Hold for 5 cycles at count 2: first tick moves from 4 to 9.
        launch(4, 0, 1'b1);
        repeat (2) cycle();
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4, 0);
        for (int k = 3; k <= 7; k++) begin
            cycle();
            check("hold_count", 32'(count), 32'd2);
            check("hold_tick", 32'(tick), 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 4, 0);
        for (int k = 8; k <= 13; k++) begin
            cycle();
            check("post_hold_tick", 32'(tick), (k == 9 || k == 13) ? 32'd1 : 32'd0);
        end
        do_abort();

        // Abort on the terminal-count edge suppresses the tick.
        launch(4, 0, 1'b1);
        repeat (3) cycle();
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4, 0);
        cycle();
        check("abort_tick", 32'(tick), 32'd0);
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        // start together with abort in IDLE stays IDLE.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4, 0);
        cycle();
        check("start_abort_busy", 32'(busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);

        // Zero period raises a single-cycle err.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 3);
        cycle();
        check("err_pulse", 32'(err), 32'd1);
        check("err_busy", 32'(busy), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 3);
        cycle();
        check("err_clear", 32'(err), 32'd0);

        // Period 1: tick every cycle, count stays 0.
        launch(1, 0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            check("p1_tick", 32'(tick), 32'd1);
            check("p1_count", 32'(count), 32'd0);
        end
        do_abort();

        // Randomized stimulus against the model.
        h_burst = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            int p;
            int ps;
            r  = int'($urandom_range(0, 19));
            p  = (r == 0) ? 0 : ((r == 1) ? 255 : int'($urandom_range(1, 6)));
            ps = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) h_burst = ~h_burst;
            drive($urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0,
                  h_burst, $urandom_range(0, 1) == 1, p, ps);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Programmable controller that sequences a free-running up-counter datapath into timed periods. Software or upstream logic supplies a period and a prescale divider, then starts it. The block produces a terminal-count tick, a live count value, and busy/done status. It supports one-shot and auto-reload modes, hold/pause, and abort. It sits between control logic and any consumer needing periodic strobes (blinkers, sample timers).

Parameters:
WIDTH, 8, width of the period and count registers.
PWIDTH, 4, width of the prescale divider value.

Ports:
clock  input  1  rising-edge clock, sole clock domain
reset  input  1  asynchronous, active-high reset
start  input  1  launch request; sampled only in IDLE or DONE
abort  input  1  return to IDLE immediately; highest priority
hold  input  1  while high in RUN, freeze all counters
auto_reload  input  1  1 = periodic, 0 = one-shot; latched at start
period  input  WIDTH  counts per period; latched at start
prescale  input  PWIDTH  clock cycles per count step minus 1; latched at start
count  output  WIDTH  current count value
busy  output  1  high in RUN or HOLD
tick  output  1  one-cycle pulse at each terminal count
done  output  1  high in DONE (one-shot completed)
err  output  1  one-cycle pulse when start is requested with period == 0

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset forces state=IDLE, count=0, prescale counter=0, busy=0, tick=0, done=0, err=0, and clears the shadow registers.
- Outputs: all registered; no combinational input-to-output paths.
- States: IDLE, RUN, HOLD, DONE.
- IDLE/DONE with start=1:
  - If period==0: err=1 for one cycle; stay in or return to IDLE; done cleared.
  - Otherwise: latch period, prescale and auto_reload into shadow registers; count=0; prescale counter=0; done=0; go to RUN.
  - busy rises on the edge that samples start.
- RUN, prescale stepping:
  - The prescale counter increments every cycle.
  - When it equals the latched prescale, it returns to 0 and a step occurs.
  - Step rate: one per (prescale+1) cycles.
- RUN, on a step:
  - If count == period_l-1: count wraps to 0 and tick=1 on the next cycle.
    - auto_reload_l=1: remain in RUN.
    - auto_reload_l=0: go to DONE.
  - Otherwise: count += 1, mod 2^WIDTH.
  - Tick spacing: period*(prescale+1) cycles.
- HOLD:
  - Entered from RUN when hold=1; returns to RUN when hold=0.
  - count and the prescale counter are frozen; no tick.
  - A hold asserted on the same edge as a step suppresses that step.
- Input changes while running: start in RUN or HOLD is ignored. period, prescale and auto_reload changes take effect only at the next start.
- DONE: done=1 and busy=0, held until start or abort. count remains 0.
- abort=1 in any state (sampled on the edge):
  - state=IDLE, count=0, prescale counter=0, done=0.
  - No tick, even if a terminal count coincides.
  - abort overrides start on the same edge.
- Simultaneous start+hold in IDLE: go to RUN; HOLD is entered on the next edge if hold is still high.
- period=1: tick every (prescale+1) cycles; count stays 0.
- Maximum period 2^WIDTH-1: the compare uses period_l-1, so there is no overflow.

Decomposition:
- Shared package count_seq_pkg: state encoding constants (IDLE=2'd0, RUN=2'd1, HOLD=2'd2, DONE=2'd3) and default WIDTH/PWIDTH.
- One natural sub-module, count_prescaler:
  - Inputs: clock, reset, clear, enable, div value.
  - Output: single-cycle step strobe.
  - Instantiated once; the FSM and count register stay in the top module.

Test Plan:
- Reset mid-RUN (period=5, count=3) -> count=0, busy=0, tick=0, done=0 immediately, without waiting for a clock edge.
- start with period=4, prescale=0, auto_reload=1 -> count sequence 1,2,3,0; tick high on cycles 4, 8, 12 after start; busy stays 1.
- start with period=3, prescale=2, auto_reload=0 -> count steps every 3 cycles; tick at cycle 9; done=1 and busy=0 from cycle 9; a later start relaunches with done=0.
- RUN with period=4, prescale=0; hold for 5 cycles at count=2 -> count stays 2 and no tick during hold; tick arrives 5 cycles later than the unheld case.
- abort on the exact edge count==period-1 with a step -> no tick; state IDLE; count=0. Separately, start+abort together in IDLE -> remains IDLE.
- start with period=0 -> err pulse of 1 cycle, busy stays 0. Also: start with period=1, prescale=0 -> tick every cycle and count constant 0.
